pulse_stretcher: RTL and testbench

- Drives a human-visible output from single-cycle strobes: each accepted strobe on Pi produces one Lo high interval of ON_CYCLES, followed by a mandatory low gap of OFF_CYCLES.
- Sits downstream of the button synchronizer and processor event strobes, and drives board LEDs or status outputs.
- Strobes that arrive while a blink is in progress are queued in a saturating pending counter, so back-to-back events stay visibly distinct.

---
 rtl/pulse_stretcher_pkg.sv | 28 ++
 rtl/pulse_stretcher_load_down_counter.sv | 30 +++
 rtl/pulse_stretcher.sv | 140 ++++++++++++++
 tb/tb_pulse_stretcher.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/pulse_stretcher_pkg.sv
// Shared types and default timing for the LED/status pulse stretcher.
package pulse_stretcher_pkg;

  // Blink state; the fourth encoding is never entered on purpose and falls back to IDLE.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ON     = 2'd1,
    GAP    = 2'd2,
    UNUSED = 2'd3
  } state_t;

  // Board clock and the human-visible defaults derived from it.
  localparam int CLK_HZ         = 50_000_000;
  localparam int DEF_ON_CYCLES  = CLK_HZ / 2;  // 0.5 s lit
  localparam int DEF_OFF_CYCLES = CLK_HZ / 4;  // 0.25 s forced dark gap
  localparam int DEF_PEND_W     = 3;

  // Timer width covering the longer of the two phases; at least one bit so
  // that ON_CYCLES = OFF_CYCLES = 1 still yields a legal vector.
  function automatic int timer_width(input int on_c, input int off_c);
    int m;
    int w;
    m = (on_c > off_c) ? on_c : off_c;
    w = $clog2(m);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/pulse_stretcher_load_down_counter.sv
// Loadable down-counter used as the ON/GAP phase timer.
module load_down_counter
  import pulse_stretcher_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         Load,
  input  logic [W-1:0] LoadVal,
  input  logic         Dec,
  output logic         Zero
);

  logic [W-1:0] count_reg;

  // Load wins over decrement; the count parks at zero instead of wrapping.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      count_reg <= '0;
    end else if (Load) begin
      count_reg <= LoadVal;
    end else if (Dec && (count_reg != '0)) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign Zero = (count_reg == '0);

endmodule

// File: rtl/pulse_stretcher.sv
// Stretches single-cycle event strobes into visible blinks: ON_CYCLES high,
// then a mandatory OFF_CYCLES low gap. Events arriving mid-blink are queued
// in a saturating counter and replayed back to back.
module pulse_stretcher
  import pulse_stretcher_pkg::*;
#(
  parameter int ON_CYCLES  = DEF_ON_CYCLES,
  parameter int OFF_CYCLES = DEF_OFF_CYCLES,
  parameter int PEND_W     = DEF_PEND_W
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Pi,
  output logic              Lo,
  output logic              Busy,
  output logic [PEND_W-1:0] Pending,
  output logic              Ovf
);

  localparam int              TW       = timer_width(ON_CYCLES, OFF_CYCLES);
  localparam logic [TW-1:0]   ON_LOAD  = TW'(ON_CYCLES - 1);
  localparam logic [TW-1:0]   OFF_LOAD = TW'(OFF_CYCLES - 1);
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  // Reject degenerate timings at elaboration.
  if (ON_CYCLES < 1) begin : g_bad_on
    $error("pulse_stretcher: ON_CYCLES must be >= 1");
  end
  if (OFF_CYCLES < 1) begin : g_bad_off
    $error("pulse_stretcher: OFF_CYCLES must be >= 1");
  end
  if (PEND_W < 1) begin : g_bad_pend
    $error("pulse_stretcher: PEND_W must be >= 1");
  end

  state_t              state_reg, state_next;
  logic                lo_reg, busy_reg, ovf_reg, ovf_next;
  logic [PEND_W-1:0]   pending_reg, pending_next;
  logic                timer_zero, timer_load, timer_dec;
  logic [TW-1:0]       timer_load_val;
  logic                push, pop;

  // Phase timer: reloaded on every entry into ON or GAP.
  load_down_counter #(
    .W (TW)
  ) u_timer (
    .Clk     (Clk),
    .Reset   (Reset),
    .Load    (timer_load),
    .LoadVal (timer_load_val),
    .Dec     (timer_dec),
    .Zero    (timer_zero)
  );

  assign timer_dec = ((state_reg == ON) || (state_reg == GAP)) && !timer_zero;

  // Next-state, timer reload and queue push/pop decisions.
  always_comb begin
    state_next     = state_reg;
    timer_load     = 1'b0;
    timer_load_val = ON_LOAD;
    push           = 1'b0;
    pop            = 1'b0;
    case (state_reg)
      IDLE: begin
        // Strobe in idle starts a blink directly; it is never queued.
        if (Pi) begin
          state_next = ON;
          timer_load = 1'b1;
        end
      end
      ON: begin
        push = Pi;
        if (timer_zero) begin
          state_next     = GAP;
          timer_load     = 1'b1;
          timer_load_val = OFF_LOAD;
        end
      end
      GAP: begin
        if (timer_zero) begin
          if (pending_reg != '0) begin
            // Replay a queued event; a coincident strobe takes its place in the queue.
            state_next = ON;
            timer_load = 1'b1;
            pop        = 1'b1;
            push       = Pi;
          end else if (Pi) begin
            // Strobe on the final gap cycle is consumed directly.
            state_next = ON;
            timer_load = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end else begin
          push = Pi;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Saturating pending counter with sticky overflow flag.
  always_comb begin
    pending_next = pending_reg;
    ovf_next     = ovf_reg;
    if (push && !pop) begin
      if (pending_reg == PEND_MAX) begin
        ovf_next = 1'b1;
      end else begin
        pending_next = pending_reg + 1'b1;
      end
    end else if (pop && !push) begin
      pending_next = pending_reg - 1'b1;
    end
  end

  // State and registered Moore outputs, cleared asynchronously.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_reg   <= IDLE;
      lo_reg      <= 1'b0;
      busy_reg    <= 1'b0;
      pending_reg <= '0;
      ovf_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      lo_reg      <= (state_next == ON);
      busy_reg    <= (state_next != IDLE);
      pending_reg <= pending_next;
      ovf_reg     <= ovf_next;
    end
  end

  assign Lo      = lo_reg;
  assign Busy    = busy_reg;
  assign Pending = pending_reg;
  assign Ovf     = ovf_reg;

endmodule

// File: tb/tb_pulse_stretcher.sv
// Directed bench for pulse_stretcher with ON_CYCLES=4, OFF_CYCLES=2, PEND_W=2.
module tb_pulse_stretcher;

  logic       Clk;
  logic       Reset;
  logic       Pi;
  logic       Lo;
  logic       Busy;
  logic [1:0] Pending;
  logic       Ovf;

  int checks = 0;
  int errors = 0;

  pulse_stretcher #(
    .ON_CYCLES  (4),
    .OFF_CYCLES (2),
    .PEND_W     (2)
  ) dut (
    .Clk     (Clk),
    .Reset   (Reset),
    .Pi      (Pi),
    .Lo      (Lo),
    .Busy    (Busy),
    .Pending (Pending),
    .Ovf     (Ovf)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic e_lo, input logic e_busy,
                           input int e_pend, input logic e_ovf);
    check({tag, ".lo"},   32'(Lo),      32'(e_lo));
    check({tag, ".busy"}, 32'(Busy),    32'(e_busy));
    check({tag, ".pend"}, 32'(Pending), 32'(e_pend));
    check({tag, ".ovf"},  32'(Ovf),     32'(e_ovf));
  endtask

  // One clock: Pi held across the edge, outputs sampled 1 ns after it.
  task automatic cyc(input string tag, input logic pi, input logic e_lo, input logic e_busy,
                     input int e_pend, input logic e_ovf);
    Pi = pi;
    @(posedge Clk);
    #1;
    Pi = 1'b0;
    check_all(tag, e_lo, e_busy, e_pend, e_ovf);
    $display("%0t %s pi=%0b lo=%0b busy=%0b pend=%0d ovf=%0b",
             $time, tag, pi, Lo, Busy, Pending, Ovf);
  endtask

  // n_on remaining lit cycles followed by the two-cycle dark gap, no new strobes.
  task automatic on_gap(input string tag, input int n_on, input int pend, input logic ovf);
    for (int i = 0; i < n_on; i++) cyc(tag, 1'b0, 1'b1, 1'b1, pend, ovf);
    cyc(tag, 1'b0, 1'b0, 1'b1, pend, ovf);
    cyc(tag, 1'b0, 1'b0, 1'b1, pend, ovf);
  endtask

  // Reset raised between edges; outputs must clear before any clock edge.
  task automatic async_reset(input string tag);
    #2;
    Reset = 1'b1;
    #1;
    check_all(tag, 1'b0, 1'b0, 0, 1'b0);
    $display("%0t %s async reset lo=%0b busy=%0b pend=%0d ovf=%0b",
             $time, tag, Lo, Busy, Pending, Ovf);
    @(posedge Clk);
    #1;
    Reset = 1'b0;
  endtask

  // Single strobe: 4 lit, 2 dark, then idle.
  task automatic single_blink(input string tag);
    cyc(tag, 1'b1, 1'b1, 1'b1, 0, 1'b0);
    on_gap(tag, 3, 0, 1'b0);
    cyc(tag, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    cyc(tag, 1'b0, 1'b0, 1'b0, 0, 1'b0);
  endtask

  initial begin
    Pi    = 1'b0;
    Reset = 1'b0;
    #1;
    Reset = 1'b1;
    #1;
    check_all("reset", 1'b0, 1'b0, 0, 1'b0);
    @(posedge Clk);
    #1;
    Reset = 1'b0;

    // 1: single strobe timing
    single_blink("t1");

    // 2: second strobe queued while lit, replayed after the gap
    async_reset("r2");
    cyc("t2", 1'b1, 1'b1, 1'b1, 0, 1'b0);
    cyc("t2", 1'b0, 1'b1, 1'b1, 0, 1'b0);
    cyc("t2", 1'b1, 1'b1, 1'b1, 1, 1'b0);
    cyc("t2", 1'b0, 1'b1, 1'b1, 1, 1'b0);
    cyc("t2", 1'b0, 1'b0, 1'b1, 1, 1'b0);
    cyc("t2", 1'b0, 1'b0, 1'b1, 1, 1'b0);
    on_gap("t2", 4, 0, 1'b0);
    cyc("t2", 1'b0, 1'b0, 1'b0, 0, 1'b0);

    // 4: strobe on the final gap cycle restarts with no idle cycle
    async_reset("r4");
    cyc("t4", 1'b1, 1'b1, 1'b1, 0, 1'b0);
    on_gap("t4", 3, 0, 1'b0);
    cyc("t4", 1'b1, 1'b1, 1'b1, 0, 1'b0);
    on_gap("t4", 3, 0, 1'b0);
    cyc("t4", 1'b0, 1'b0, 1'b0, 0, 1'b0);

    // 5: pop and push on the final gap cycle leave Pending unchanged
    async_reset("r5");
    cyc("t5", 1'b1, 1'b1, 1'b1, 0, 1'b0);
    cyc("t5", 1'b0, 1'b1, 1'b1, 0, 1'b0);
    cyc("t5", 1'b1, 1'b1, 1'b1, 1, 1'b0);
    cyc("t5", 1'b0, 1'b1, 1'b1, 1, 1'b0);
    cyc("t5", 1'b0, 1'b0, 1'b1, 1, 1'b0);
    cyc("t5", 1'b0, 1'b0, 1'b1, 1, 1'b0);
    cyc("t5", 1'b1, 1'b1, 1'b1, 1, 1'b0);
    on_gap("t5", 3, 1, 1'b0);
    cyc("t5", 1'b0, 1'b1, 1'b1, 0, 1'b0);
    on_gap("t5", 3, 0, 1'b0);
    cyc("t5", 1'b0, 1'b0, 1'b0, 0, 1'b0);

    // 3: six-cycle burst saturates the queue and sets sticky overflow
    async_reset("r3");
    cyc("t3", 1'b1, 1'b1, 1'b1, 0, 1'b0);
    cyc("t3", 1'b1, 1'b1, 1'b1, 1, 1'b0);
    cyc("t3", 1'b1, 1'b1, 1'b1, 2, 1'b0);
    cyc("t3", 1'b1, 1'b1, 1'b1, 3, 1'b0);
    cyc("t3", 1'b1, 1'b0, 1'b1, 3, 1'b1);
    cyc("t3", 1'b1, 1'b0, 1'b1, 3, 1'b1);
    on_gap("t3", 4, 2, 1'b1);
    on_gap("t3", 4, 1, 1'b1);
    on_gap("t3", 4, 0, 1'b1);
    cyc("t3", 1'b0, 1'b0, 1'b0, 0, 1'b1);
    cyc("t3", 1'b0, 1'b0, 1'b0, 0, 1'b1);

    // 6: async reset mid-blink clears everything, including sticky Ovf
    cyc("t6", 1'b1, 1'b1, 1'b1, 0, 1'b1);
    cyc("t6", 1'b1, 1'b1, 1'b1, 1, 1'b1);
    async_reset("t6");
    single_blink("t6b");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
